// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three 2-deep writeback FIFOs, round-robin arbitrated onto one registered CDB.
package ooop_types;
  localparam int XLEN   = 32;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;
  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob_tag;
    logic [PREG_W-1:0] prd;
    logic [XLEN-1:0]   data;
    logic              rd_used;
  } wb_pkt_t;
endpackage

module cdb_arbiter
  import ooop_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  wb_pkt_t    alu_wb,
  input  wb_pkt_t    lsu_wb,
  input  wb_pkt_t    bru_wb,
  output logic       alu_rdy,
  output logic       lsu_rdy,
  output logic       bru_rdy,
  output wb_pkt_t    cdb,
  output logic [1:0] cdb_src
);
  wb_pkt_t    req [3];
  wb_pkt_t    mem [3][2];
  logic [1:0] cnt [3];
  logic [2:0] hd, tl, ne, rdy, push, pop;
  logic [1:0] rr_ptr, rr, c1, c2, gnt_s;
  logic       gnt;
  always_comb begin
    req[0] = alu_wb;
    req[1] = lsu_wb;
    req[2] = bru_wb;
    rr     = rr_ptr == 2'd3 ? 2'd0 : rr_ptr;
    c1     = rr == 2'd2 ? 2'd0 : rr + 2'd1;
    c2     = rr == 2'd0 ? 2'd2 : rr - 2'd1;
    for (int i = 0; i < 3; i++) begin
      ne[i]   = cnt[i] != 2'd0;
      rdy[i]  = rst_n && cnt[i] < 2'd2 && !flush;
      push[i] = req[i].valid && rdy[i];
    end
    gnt   = |ne;
    gnt_s = ne[rr] ? rr : ne[c1] ? c1 : c2;
    for (int i = 0; i < 3; i++) pop[i] = gnt && gnt_s == 2'(i);
    {bru_rdy, lsu_rdy, alu_rdy} = rdy;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cnt[i] <= 2'd0;
      hd      <= '0;
      tl      <= '0;
      rr_ptr  <= '0;
      cdb     <= '0;
      cdb_src <= '0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) cnt[i] <= 2'd0;
      hd        <= '0;
      tl        <= '0;
      cdb.valid <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) cnt[i] <= cnt[i] + 2'(push[i]) - 2'(pop[i]);
      hd <= hd ^ pop;
      tl <= tl ^ push;
      if (gnt) begin
        cdb     <= mem[gnt_s][hd[gnt_s]];
        cdb_src <= gnt_s;
        rr_ptr  <= gnt_s == 2'd2 ? 2'd0 : gnt_s + 2'd1;
      end
      cdb.valid <= gnt;
    end
  end
  // storage needs no reset: counts alone decide what is live
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (push[i]) mem[i][tl[i]] <= req[i];
  end
endmodule
